// File: rtl/ingress_voq_array.sv
// Ingress port with one virtual output queue per egress port.
// Incoming metadata is sorted by its destination field and stamped with its
// arrival time. The scheduler pops one head entry per grant; the popped entry
// leaves registered, together with the time it spent queued.
module ingress_voq_array #(
  parameter int N_PORTS    = 4,
  parameter int DEPTH      = 256,
  parameter int META_WIDTH = 32,
  parameter int TS_WIDTH   = 11,
  parameter int DEST_LSB   = 28,
  parameter int DROP_W     = 16,
  localparam int PW = $clog2(N_PORTS),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [META_WIDTH-1:0]     ingress_in,
  input  logic                      ingress_in_en,
  input  logic [TS_WIDTH-1:0]       time_stamp,
  input  logic                      sched_en,
  input  logic [PW-1:0]             sched_sel,
  input  logic                      drop_clr,
  output logic [META_WIDTH-1:0]     ingress_out,
  output logic [TS_WIDTH-1:0]       out_latency,
  output logic                      ingress_out_en,
  output logic [N_PORTS-1:0]        is_empty,
  output logic [N_PORTS-1:0]        is_full,
  output logic [N_PORTS*CW-1:0]     occupancy,
  output logic [N_PORTS*DROP_W-1:0] drop_cnt
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // All VOQs share one storage array; the VOQ number forms the upper address bits.
  logic [META_WIDTH-1:0] mem [N_PORTS*DEPTH];

  // Pointers carry an extra wrap bit so that full and empty can be told apart.
  logic [CW-1:0]     head  [N_PORTS];
  logic [CW-1:0]     tail  [N_PORTS];
  logic [CW-1:0]     cnt   [N_PORTS];
  logic [DROP_W-1:0] drops [N_PORTS];

  logic [PW-1:0]         enq_dest;
  logic                  enq_ok;
  logic                  enq_drop;
  logic                  deq_ok;
  logic [META_WIDTH-1:0] enq_data;
  logic [META_WIDTH-1:0] head_entry;

  // The stamp overwrites the low bits of the incoming word, so those bits are never read.
  logic unused_ts_bits;
  assign unused_ts_bits = ^ingress_in[TS_WIDTH-1:0];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_status
    assign cnt[g]                         = tail[g] - head[g];
    assign is_empty[g]                    = (cnt[g] == '0);
    assign is_full[g]                     = (cnt[g] == FULL_CNT);
    assign occupancy[g*CW +: CW]          = cnt[g];
    assign drop_cnt[g*DROP_W +: DROP_W]   = drops[g];
  end

  assign enq_dest   = ingress_in[DEST_LSB +: PW];
  assign enq_ok     = ingress_in_en && !is_full[enq_dest];
  assign enq_drop   = ingress_in_en &&  is_full[enq_dest];
  assign deq_ok     = sched_en && !is_empty[sched_sel];
  assign enq_data   = {ingress_in[META_WIDTH-1:TS_WIDTH], time_stamp};
  assign head_entry = mem[{sched_sel, head[sched_sel][AW-1:0]}];

  // Storage write at the tail of the destination VOQ; contents need no reset.
  always_ff @(posedge clk) begin
    if (reset && enq_ok) begin
      mem[{enq_dest, tail[enq_dest][AW-1:0]}] <= enq_data;
    end
  end

  // Head/tail pointer advance; an enqueue and a dequeue on one VOQ both apply.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
      end
    end else begin
      if (enq_ok) tail[enq_dest]  <= tail[enq_dest] + CW'(1);
      if (deq_ok) head[sched_sel] <= head[sched_sel] + CW'(1);
    end
  end

  // Saturating per-VOQ drop counters; a clear discards a drop arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_PORTS; i++) drops[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (drop_clr) begin
          drops[i] <= '0;
        end else if (enq_drop && enq_dest == PW'(i) && drops[i] != '1) begin
          drops[i] <= drops[i] + DROP_W'(1);
        end
      end
    end
  end

  // Registered output stage: one pulse per accepted grant, data held otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ingress_out    <= '0;
      out_latency    <= '0;
      ingress_out_en <= 1'b0;
    end else begin
      ingress_out_en <= deq_ok;
      if (deq_ok) begin
        ingress_out <= head_entry;
        out_latency <= time_stamp - head_entry[TS_WIDTH-1:0];
      end
    end
  end

endmodule
